// File: rtl/board_button_ctrl.sv
// Front-panel conditioner: button sync/debounce, short/long press decoding, turbo/user/reset actions, activity LED.
// Optional macro ACTIVITY_STRETCH_EN stretches activity strobes into a visible FLASH_MS flash.
module board_button_ctrl #(
  parameter int CLK_MHZ     = 50,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int FLASH_MS    = 20
) (
  input  logic clk_chipset,
  input  logic reset_n,
  input  logic btn_green_n_i,
  input  logic btn_yellow_n_i,
  input  logic activity_i,
  output logic turbo_o,
  output logic green_short_o,
  output logic sys_reset_req_o,
  output logic led_activity_o
);

  localparam int TICK_CNT   = CLK_MHZ * 1000;
  localparam int PRE_W      = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam int DB_W       = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W     = $clog2(LONG_MS + 1);
  localparam int BTN_GREEN  = 0;
  localparam int BTN_YELLOW = 1;

  typedef enum logic [1:0] {IDLE, PRESSED, HELD, LOCKOUT} press_state_t;

  // A zero-length interval would leave a counter unable to reach its terminal value.
  if (CLK_MHZ < 1 || DEBOUNCE_MS < 1 || LONG_MS < 1 || FLASH_MS < 1) begin : g_bad_param
    $error("board_button_ctrl: all timing parameters must be at least 1");
  end

  logic [PRE_W-1:0] presc_reg;
  logic             tick;

  assign tick = (presc_reg == PRE_W'(TICK_CNT - 1));

  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n)  presc_reg <= '0;
    else if (tick) presc_reg <= '0;
    else           presc_reg <= presc_reg + 1'b1;
  end

  logic [1:0] btn_raw_n;
  logic [1:0] db_pressed;
  logic [1:0] short_evt;
  logic [1:0] long_evt;
  logic       chord;

  assign btn_raw_n = {btn_yellow_n_i, btn_green_n_i};
  assign chord     = &db_pressed;

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic [1:0]        sync_n_reg;
    logic              db_reg;
    logic [DB_W-1:0]   db_cnt_reg;
    press_state_t      state_reg, state_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic              short_next, long_next;

    // Debounced state flips only after DEBOUNCE_MS consecutive ticks of disagreement.
    always_ff @(posedge clk_chipset or negedge reset_n) begin
      if (!reset_n) begin
        sync_n_reg <= 2'b11;
        db_reg     <= 1'b0;
        db_cnt_reg <= '0;
      end else begin
        sync_n_reg <= {sync_n_reg[0], btn_raw_n[gi]};
        if (~sync_n_reg[1] == db_reg) begin
          db_cnt_reg <= '0;
        end else if (tick) begin
          if (db_cnt_reg == DB_W'(DEBOUNCE_MS - 1)) begin
            db_reg     <= ~db_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
      end
    end

    assign db_pressed[gi] = db_reg;

    always_ff @(posedge clk_chipset or negedge reset_n) begin
      if (!reset_n) begin
        state_reg    <= IDLE;
        hold_cnt_reg <= '0;
      end else begin
        state_reg    <= state_next;
        hold_cnt_reg <= hold_cnt_next;
      end
    end

    always_comb begin
      state_next    = state_reg;
      hold_cnt_next = hold_cnt_reg;
      short_next    = 1'b0;
      long_next     = 1'b0;
      if (chord) begin
        state_next = LOCKOUT;
      end else begin
        case (state_reg)
          IDLE: begin
            if (db_reg) begin
              state_next    = PRESSED;
              hold_cnt_next = '0;
            end
          end
          PRESSED: begin
            if (!db_reg) begin
              short_next = 1'b1;
              state_next = IDLE;
            end else if (tick) begin
              hold_cnt_next = hold_cnt_reg + 1'b1;
              if (hold_cnt_reg == HOLD_W'(LONG_MS - 1)) begin
                long_next  = 1'b1;
                state_next = HELD;
              end
            end
          end
          HELD: begin
            if (!db_reg) state_next = IDLE;
          end
          LOCKOUT: begin
            if (db_pressed == 2'b00) state_next = IDLE;
          end
          default: state_next = IDLE;
        endcase
      end
    end

    assign short_evt[gi] = short_next;
    assign long_evt[gi]  = long_next;
  end

  logic turbo_reg, green_short_reg, sys_reset_req_reg;

  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n) begin
      turbo_reg         <= 1'b0;
      green_short_reg   <= 1'b0;
      sys_reset_req_reg <= 1'b0;
    end else begin
      turbo_reg         <= turbo_reg ^ short_evt[BTN_YELLOW];
      green_short_reg   <= short_evt[BTN_GREEN];
      sys_reset_req_reg <= long_evt[BTN_GREEN];
    end
  end

  logic [1:0] act_sync_reg;
  logic       led_reg;

  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n) act_sync_reg <= 2'b00;
    else          act_sync_reg <= {act_sync_reg[0], activity_i};
  end

`ifdef ACTIVITY_STRETCH_EN
  localparam int FL_W = $clog2(FLASH_MS + 1);

  logic            act_d_reg;
  logic [FL_W-1:0] flash_cnt_reg, flash_cnt_next;

  // A fresh rising edge always reloads, so back-to-back bursts keep the LED lit.
  always_comb begin
    flash_cnt_next = flash_cnt_reg;
    if (act_sync_reg[1] && !act_d_reg)
      flash_cnt_next = FL_W'(FLASH_MS);
    else if (tick && (flash_cnt_reg != '0))
      flash_cnt_next = flash_cnt_reg - 1'b1;
  end

  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n) begin
      act_d_reg     <= 1'b0;
      flash_cnt_reg <= '0;
      led_reg       <= 1'b0;
    end else begin
      act_d_reg     <= act_sync_reg[1];
      flash_cnt_reg <= flash_cnt_next;
      led_reg       <= (flash_cnt_next != '0);
    end
  end
`else
  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n) led_reg <= 1'b0;
    else          led_reg <= act_sync_reg[1];
  end
`endif

  assign turbo_o         = turbo_reg;
  assign green_short_o   = green_short_reg;
  assign sys_reset_req_o = sys_reset_req_reg;
  assign led_activity_o  = led_reg;

endmodule

// File: tb/tb_board_button_ctrl.sv
// Randomized bench for board_button_ctrl: press durations and bounce patterns are drawn with $urandom and
// the expected outcome of each press is derived from its duration and button mix.
module tb_board_button_ctrl;

  localparam int CLK_MHZ     = 1;
  localparam int DEBOUNCE_MS = 2;
  localparam int LONG_MS     = 10;
  localparam int FLASH_MS    = 3;
  localparam int TICK        = CLK_MHZ * 1000;
  localparam int SETTLE      = 2200;

  logic clk_chipset    = 1'b0;
  logic reset_n        = 1'b0;
  logic btn_green_n_i  = 1'b1;
  logic btn_yellow_n_i = 1'b1;
  logic activity_i     = 1'b0;
  logic turbo_o, green_short_o, sys_reset_req_o, led_activity_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int   gs_total = 0, rr_total = 0, tc_total = 0;
  int   gs_last  = 0, rr_last  = 0, tc_last  = 0;
  logic turbo_prev  = 1'b0;
  bit   turbo_model = 1'b0;

  board_button_ctrl #(
    .CLK_MHZ    (CLK_MHZ),
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .LONG_MS    (LONG_MS),
    .FLASH_MS   (FLASH_MS)
  ) dut (
    .clk_chipset    (clk_chipset),
    .reset_n        (reset_n),
    .btn_green_n_i  (btn_green_n_i),
    .btn_yellow_n_i (btn_yellow_n_i),
    .activity_i     (activity_i),
    .turbo_o        (turbo_o),
    .green_short_o  (green_short_o),
    .sys_reset_req_o(sys_reset_req_o),
    .led_activity_o (led_activity_o)
  );

  always #5 clk_chipset = ~clk_chipset;

  always @(posedge clk_chipset) cyc <= cyc + 1;

  // Output monitor: counts high cycles of each pulse output and every turbo level change.
  always @(negedge clk_chipset) begin
    if (green_short_o === 1'b1) begin
      gs_total++;
      gs_last = cyc;
    end
    if (sys_reset_req_o === 1'b1) begin
      rr_total++;
      rr_last = cyc;
    end
    if (turbo_o !== turbo_prev) begin
      tc_total++;
      tc_last = cyc;
    end
    turbo_prev = turbo_o;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_chipset);
    #1;
  endtask

  function automatic bit in_window(input int delta, input int lo, input int hi);
    return (delta >= lo) && (delta <= hi);
  endfunction

  // One press transaction; the expected result follows from hold time and which buttons were used.
  task automatic run_press(input string name, input bit use_g, input bit use_y,
                           input int dur, input int stagger);
    int gs0, rr0, tc0, p_cyc, r_cyc;
    bit is_long, exp_gs, exp_rr, exp_tc;
    gs0 = gs_total; rr0 = rr_total; tc0 = tc_total;
    p_cyc = cyc;
    if (use_y) btn_yellow_n_i = 1'b0;
    if (stagger > 0) wait_cycles(stagger);
    if (use_g) btn_green_n_i = 1'b0;
    wait_cycles(dur);
    if (use_y) btn_yellow_n_i = 1'b1;
    if (stagger > 0) wait_cycles(stagger);
    if (use_g) btn_green_n_i = 1'b1;
    r_cyc = cyc;
    wait_cycles(SETTLE);

    is_long = (dur >= (LONG_MS + 1) * TICK);
    exp_gs  = use_g && !use_y && !is_long;
    exp_rr  = use_g && !use_y &&  is_long;
    exp_tc  = use_y && !use_g && !is_long;
    turbo_model ^= exp_tc;

    check_val({name, "_green_short_cnt"}, gs_total - gs0, 32'(exp_gs));
    check_val({name, "_reset_req_cnt"},   rr_total - rr0, 32'(exp_rr));
    check_val({name, "_turbo_changes"},   tc_total - tc0, 32'(exp_tc));
    check_val({name, "_turbo"},           32'(turbo_o),   32'(turbo_model));
    if (exp_gs) check_val({name, "_gs_latency_ok"}, 32'(in_window(gs_last - r_cyc, 1000, 2010)), 1);
    if (exp_tc) check_val({name, "_turbo_latency_ok"}, 32'(in_window(tc_last - r_cyc, 1000, 2010)), 1);
    if (exp_rr) check_val({name, "_rr_latency_ok"}, 32'(in_window(rr_last - p_cyc, 10900, 12100)), 1);
    $display("txn %s: g=%0d y=%0d dur=%0d stagger=%0d -> green_short=%0d reset_req=%0d turbo=%0d",
             name, use_g, use_y, dur, stagger, gs_total - gs0, rr_total - rr0, turbo_o);
  endtask

  task automatic run_bounce();
    int gs0, rr0, tc0, elapsed, seg;
    bit lvl;
    gs0 = gs_total; rr0 = rr_total; tc0 = tc_total;
    elapsed = 0;
    lvl = 1'b0;
    while (elapsed < 3000) begin
      seg = $urandom_range(200, 900);
      btn_yellow_n_i = lvl;
      wait_cycles(seg);
      elapsed += seg;
      lvl = ~lvl;
    end
    btn_yellow_n_i = 1'b1;
    wait_cycles(SETTLE);
    check_val("bounce_turbo_changes", tc_total - tc0, 0);
    check_val("bounce_turbo",         32'(turbo_o),   32'(turbo_model));
    check_val("bounce_green_short",   gs_total - gs0, 0);
    check_val("bounce_reset_req",     rr_total - rr0, 0);
    $display("txn bounce: %0d cycles of chatter -> turbo=%0d", elapsed, turbo_o);
  endtask

  // Reset while yellow is held: outputs clear at once, and the still-held button must debounce again.
  task automatic run_reset_mid_press();
    int gs0, rr0, dur;
    btn_yellow_n_i = 1'b0;
    wait_cycles(2500);
    reset_n = 1'b0;
    #1;
    turbo_model = 1'b0;
    check_val("rst_turbo",       32'(turbo_o),         0);
    check_val("rst_green_short", 32'(green_short_o),   0);
    check_val("rst_reset_req",   32'(sys_reset_req_o), 0);
    check_val("rst_led",         32'(led_activity_o),  0);
    wait_cycles(3);
    reset_n = 1'b1;
    gs0 = gs_total; rr0 = rr_total;
    dur = $urandom_range(3000, 5000);
    wait_cycles(dur);
    btn_yellow_n_i = 1'b1;
    wait_cycles(SETTLE);
    turbo_model = ~turbo_model;
    check_val("rst_then_short_turbo", 32'(turbo_o),   32'(turbo_model));
    check_val("rst_then_short_gs",    gs_total - gs0, 0);
    check_val("rst_then_short_rr",    rr_total - rr0, 0);
    $display("txn reset_mid_press: held %0d after reset -> turbo=%0d", dur, turbo_o);
  endtask

`ifdef ACTIVITY_STRETCH_EN
  task automatic measure_led(input int n, output int rises, output int high);
    logic prev;
    prev  = led_activity_o;
    rises = 0;
    high  = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_chipset);
      if (led_activity_o === 1'b1) high++;
      if (led_activity_o === 1'b1 && prev !== 1'b1) rises++;
      prev = led_activity_o;
    end
    @(posedge clk_chipset);
    #1;
  endtask

  task automatic pulse_activity();
    activity_i = 1'b1;
    wait_cycles(1);
    activity_i = 1'b0;
  endtask
`endif

  task automatic run_activity();
`ifdef ACTIVITY_STRETCH_EN
    int r1, h1, r2, h2, r3, h3;
    pulse_activity();
    measure_led(3500, r1, h1);
    check_val("flash_single_rises",   r1, 1);
    check_val("flash_single_on_ok",   32'(in_window(h1, 2000, 3005)), 1);
    $display("txn activity_single: led on %0d cycles", h1);
    pulse_activity();
    measure_led(2000, r2, h2);
    pulse_activity();
    measure_led(4000, r3, h3);
    check_val("flash_double_rises",   r2 + r3, 1);
    check_val("flash_double_on_ok",   32'(in_window(h2 + h3, 4000, 5010)), 1);
    $display("txn activity_double: led on %0d cycles, %0d rises", h2 + h3, r2 + r3);
`else
    bit hist[$];
    int bad;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_chipset);
      #1;
      activity_i = 1'($urandom_range(0, 1));
      @(negedge clk_chipset);
      hist.push_back(activity_i);
      if (i >= 3) begin
        if (led_activity_o !== hist[i-3]) bad++;
        check_val("led_follows_activity", 32'(led_activity_o), 32'(hist[i-3]));
      end
    end
    activity_i = 1'b0;
    wait_cycles(5);
    $display("txn activity_passthrough: 197 samples, %0d off", bad);
`endif
  endtask

  initial begin
    wait_cycles(5);
    @(negedge clk_chipset);
    check_val("reset_turbo",       32'(turbo_o),         0);
    check_val("reset_green_short", 32'(green_short_o),   0);
    check_val("reset_reset_req",   32'(sys_reset_req_o), 0);
    check_val("reset_led",         32'(led_activity_o),  0);
    $display("txn reset: outputs turbo=%0d gs=%0d rr=%0d led=%0d",
             turbo_o, green_short_o, sys_reset_req_o, led_activity_o);
    @(posedge clk_chipset);
    #1;
    reset_n = 1'b1;
    wait_cycles(100);

    run_bounce();
    run_press("yellow_short1", 1'b0, 1'b1, $urandom_range(3000, 5000), 0);
    run_press("green_long",    1'b1, 1'b0, $urandom_range(12000, 12500), 0);
    run_press("green_short",   1'b1, 1'b0, $urandom_range(3000, 5000), 0);
    run_press("chord",         1'b1, 1'b1, $urandom_range(3000, 5000), $urandom_range(0, 500));
    run_press("yellow_long",   1'b0, 1'b1, $urandom_range(12000, 12500), 0);
    run_reset_mid_press();
    run_press("yellow_short2", 1'b0, 1'b1, $urandom_range(3000, 5000), 0);
    run_activity();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_button_ctrl.md
Name: board_button_ctrl

Overview:
Front-panel input conditioner between the UnoXT board pins and the PC/XT system core. It synchronises and debounces the two active-low board buttons (green, yellow) and classifies each press as short or long. It turns those presses into a turbo level, a user-action pulse and a system reset request. It also drives a visible activity LED from a fast, glitchy activity signal such as SD card DAT0.

Parameters:
CLK_MHZ, 50, clk_chipset frequency in MHz; 1 ms tick = CLK_MHZ*1000 cycles
DEBOUNCE_MS, 20, input must be stable this many ms ticks before debounced state changes
LONG_MS, 1000, hold time in ms ticks that makes a press "long"
FLASH_MS, 20, minimum LED on-time in ms ticks (used only with the optional feature)

Ports:
clk_chipset  in  1  single system clock; all logic is on this clock
reset_n  in  1  asynchronous active-low reset
btn_green_n_i  in  1  raw green button, 0 = pressed, asynchronous
btn_yellow_n_i  in  1  raw yellow button, 0 = pressed, asynchronous
activity_i  in  1  raw activity strobe, asynchronous, active high
turbo_o  out  1  turbo mode level, 1 = turbo
green_short_o  out  1  one-cycle pulse on green short-press release
sys_reset_req_o  out  1  one-cycle pulse when green long-hold threshold is reached
led_activity_o  out  1  activity LED drive, 1 = lit

Behaviour:
- Reset (reset_n=0, async): turbo_o=0, green_short_o=0, sys_reset_req_o=0, led_activity_o=0.
  - Both debounced states = released; both FSMs = IDLE; all counters = 0; sync flops = 1 for buttons, 0 for activity.
  - Reset deassertion mid-press: the button is treated as released and must be debounced again before it counts as pressed.
- Synchronisers: two flops per raw input. Only synchronised values are used.
- ms tick: a free-running prescaler counts 0..CLK_MHZ*1000-1. tick is high for one cycle at the terminal count, which then wraps to 0.
- Debounce, per button:
  - When the synced level equals the debounced state, the stable counter is cleared.
  - Otherwise the counter increments on each tick.
  - When it reaches DEBOUNCE_MS, the debounced state flips and the counter clears.
  - Latency from a stable raw change to the debounced change is (DEBOUNCE_MS-1)..DEBOUNCE_MS ms plus 2 cycles.
- Press FSM, per button, states IDLE, PRESSED, HELD, LOCKOUT:
  - IDLE -> PRESSED on debounced press; the hold counter clears.
  - PRESSED: hold counter increments per tick, saturating at LONG_MS.
    - Release before the counter reaches LONG_MS = short press; action is taken, then -> IDLE.
    - Counter reaching LONG_MS = long press; long action is taken, then -> HELD.
  - HELD -> IDLE on release; nothing is emitted at release.
  - LOCKOUT -> IDLE only when both debounced buttons are released.
- Actions:
  - Yellow short: turbo_o toggles on the cycle after the debounced release.
  - Yellow long: no action; turbo_o is unchanged.
  - Green short: green_short_o pulses for exactly 1 cycle on the cycle after the debounced release.
  - Green long: sys_reset_req_o pulses for exactly 1 cycle on the cycle after the counter reaches LONG_MS. It fires once per hold.
- Simultaneous press: if both debounced states are pressed in the same cycle, both FSMs go to LOCKOUT (from any state). Pending short/long actions are discarded and no outputs pulse until both buttons are released.
- Both releases in the same cycle from PRESSED: both short actions occur in that same cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

Optional Feature:
ACTIVITY_STRETCH_EN
- Defined: on each rising edge of synced activity_i, a flash counter loads FLASH_MS and led_activity_o=1 on the next cycle.
  - The counter decrements per tick; led_activity_o=0 when it reaches 0.
  - A new edge while lit reloads the counter, so the LED stays lit.
- Not defined: led_activity_o is the synced activity_i registered once (3-cycle latency); the flash counter is not built.

Test Plan:
- Sim settings: CLK_MHZ=1, DEBOUNCE_MS=2, LONG_MS=10, FLASH_MS=3.
- Bounce: yellow toggles every 300 cycles for 3000 cycles, then stays high -> no debounced press; turbo_o stays 0.
- Yellow short: low for 5 ms, then high -> turbo_o 0->1 about 2 ms after release; repeating the press -> turbo_o 1->0.
- Green long: low for 15 ms -> exactly one sys_reset_req_o pulse about 12 ms after the press edge; no green_short_o on release.
- Green short: low for 4 ms -> one green_short_o pulse after the debounced release; sys_reset_req_o stays 0.
- Chord and reset: both buttons low together 5 ms, then released -> no pulses, turbo_o unchanged. Asserting reset_n=0 while yellow is held -> all outputs 0 immediately.
- Activity, with ACTIVITY_STRETCH_EN: 1-cycle activity_i pulse -> led_activity_o high for 2..3 ms. A second pulse 2 ms later -> the LED stays continuously lit.
